// File: rtl/timer_alarm_sched_pkg.sv
// rtl/timer_alarm_sched_pkg.sv - shared register map, channel state and read helper
package timer_alarm_sched_pkg;

  localparam int CH_W = 2;

  localparam logic [1:0] REG_CMP    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int STAT_PENDING  = 0;
  localparam int STAT_OVERRUN  = 1;

  typedef struct packed {
    logic [31:0] cmp;
    logic [31:0] period;
    logic        en;
    logic        periodic;
    logic        pending;
    logic        overrun;
  } ch_state_t;

  function automatic logic [31:0] read_reg(ch_state_t s, logic [1:0] r);
    case (r)
      REG_CMP:    return s.cmp;
      REG_PERIOD: return s.period;
      REG_CTRL:   return {30'b0, s.periodic, s.en};
      default:    return {30'b0, s.overrun, s.pending};
    endcase
  endfunction

endpackage

// File: rtl/timer_alarm_sched_if.sv
// rtl/timer_alarm_sched_if.sv - MMIO register bus plus shared interrupt handshake
interface timer_alarm_sched_if;
  import timer_alarm_sched_pkg::*;

  logic            sel;
  logic            we;
  logic            re;
  logic [3:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;
  logic [CH_W-1:0] irq_id;
  logic            irq_ack;

  modport master (
    output sel, we, re, addr, wdata, irq_ack,
    input  rdata, irq, irq_id
  );

  modport slave (
    input  sel, we, re, addr, wdata, irq_ack,
    output rdata, irq, irq_id
  );
endinterface

// File: rtl/timer_alarm_sched_rr_arbiter.sv
// rtl/timer_alarm_sched_rr_arbiter.sv - combinational round-robin grant over a request vector
module timer_alarm_sched_rr_arbiter
  import timer_alarm_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            valid
);

  // Walk offsets from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    grant = '0;
    valid = |req;
    for (int k = N - 1; k >= 0; k--) begin
      for (int j = 0; j < N; j++) begin
        if (j == (int'(ptr) + k) % N && req[j]) grant = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// rtl/timer_alarm_sched.sv - alarm channels on the ms timebase with shared round-robin irq
// Optional: TIMER_SCHED_OVERRUN_EN adds a sticky overrun flag in STATUS bit1.
module timer_alarm_sched
  import timer_alarm_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        timer,
  timer_alarm_sched_if.slave bus
);

  ch_state_t       ch [NCH];
  logic [31:0]     timer_q;
  logic            tick;
  logic [NCH-1:0]  fire;
  logic [NCH-1:0]  pend_vec;
  logic [CH_W-1:0] rr;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] rr_next;
  logic            grant_valid;
  logic            ack;
  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [1:0]      wr_reg;
  logic [31:0]     rd_word;

  assign tick    = timer != timer_q;
  assign wr_en   = bus.sel && bus.we;
  assign wr_ch   = bus.addr[3:2];
  assign wr_reg  = bus.addr[1:0];
  assign ack     = bus.irq_ack && grant_valid;
  assign rr_next = (int'(grant) == NCH - 1) ? '0 : grant + CH_W'(1);

  always_comb begin
    fire     = '0;
    pend_vec = '0;
    rd_word  = '0;
    for (int i = 0; i < NCH; i++) begin
      fire[i]     = ch[i].en && tick && (timer == ch[i].cmp);
      pend_vec[i] = ch[i].pending;
      if (bus.addr[3:2] == CH_W'(i)) rd_word = read_reg(ch[i], bus.addr[1:0]);
    end
  end

  timer_alarm_sched_rr_arbiter #(.N(NCH)) u_arb (
    .req   (pend_vec),
    .ptr   (rr),
    .grant (grant),
    .valid (grant_valid)
  );

  assign bus.irq    = grant_valid;
  assign bus.irq_id = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      rr        <= '0;
      bus.rdata <= '0;
      for (int i = 0; i < NCH; i++) ch[i] <= '0;
    end else begin
      timer_q <= timer;
      if (ack) rr <= rr_next;
      if (bus.sel && bus.re) bus.rdata <= rd_word;
      for (int i = 0; i < NCH; i++) begin
        // Register writes override the fire's reload/auto-disable; fire still wins on pending.
        if (wr_en && wr_ch == CH_W'(i) && wr_reg == REG_CMP)
          ch[i].cmp <= bus.wdata;
        else if (fire[i] && ch[i].periodic && ch[i].period != '0)
          ch[i].cmp <= ch[i].cmp + ch[i].period;

        if (wr_en && wr_ch == CH_W'(i) && wr_reg == REG_PERIOD)
          ch[i].period <= bus.wdata;

        if (wr_en && wr_ch == CH_W'(i) && wr_reg == REG_CTRL) begin
          ch[i].en       <= bus.wdata[CTRL_EN];
          ch[i].periodic <= bus.wdata[CTRL_PERIODIC];
        end else if (fire[i] && !(ch[i].periodic && ch[i].period != '0)) begin
          ch[i].en <= 1'b0;
        end

        if (fire[i])
          ch[i].pending <= 1'b1;
        else if ((ack && grant == CH_W'(i)) ||
                 (wr_en && wr_ch == CH_W'(i) && wr_reg == REG_STATUS && bus.wdata[STAT_PENDING]))
          ch[i].pending <= 1'b0;

`ifdef TIMER_SCHED_OVERRUN_EN
        if (fire[i] && ch[i].pending)
          ch[i].overrun <= 1'b1;
        else if (wr_en && wr_ch == CH_W'(i) && wr_reg == REG_STATUS && bus.wdata[STAT_OVERRUN])
          ch[i].overrun <= 1'b0;
`else
        ch[i].overrun <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_timer_alarm_sched.sv
// tb/tb_timer_alarm_sched.sv - directed plan plus randomized traffic against a rule-level model
module tb_timer_alarm_sched;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] timer = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  timer_alarm_sched_if bus ();

  timer_alarm_sched #(.NCH(NCH)) dut (
    .clk   (clk),
    .rst   (rst),
    .timer (timer),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state, updated from the behavioural rules once per clock.
  logic [31:0] m_cmp [NCH];
  logic [31:0] m_period [NCH];
  bit          m_en [NCH];
  bit          m_per [NCH];
  bit [NCH-1:0] m_pend;
  bit          m_ov [NCH];
  int          m_rr;
  logic [31:0] m_tq;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (m_pend == '0) return 0;
    for (int k = 0; k < NCH; k++)
      if (m_pend[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int c = int'(a[3:2]);
    if (c >= NCH) return 0;
    case (a[1:0])
      2'd0: return m_cmp[c];
      2'd1: return m_period[c];
      2'd2: return {30'b0, m_per[c], m_en[c]};
      default: return {30'b0, m_ov[c], m_pend[c]};
    endcase
  endfunction

  task automatic step();
    bit tk, ack_ok, hit, rl;
    bit [NCH-1:0] f;
    int g;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cmp[i] = 0; m_period[i] = 0; m_en[i] = 0; m_per[i] = 0; m_ov[i] = 0;
      end
      m_pend = '0; m_rr = 0; m_tq = 0; m_rdata = 0;
    end else begin
      tk = (timer != m_tq);
      g = m_grant();
      ack_ok = bus.irq_ack && (m_pend != '0);
      if (bus.sel && bus.re) m_rdata = m_read(bus.addr);
      for (int i = 0; i < NCH; i++) f[i] = m_en[i] && tk && (timer == m_cmp[i]);
      for (int i = 0; i < NCH; i++) begin
        hit = bus.sel && bus.we && (int'(bus.addr[3:2]) == i);
        rl = m_per[i] && (m_period[i] != 0);
`ifdef TIMER_SCHED_OVERRUN_EN
        if (f[i] && m_pend[i]) m_ov[i] = 1;
        else if (hit && bus.addr[1:0] == 2'd3 && bus.wdata[1]) m_ov[i] = 0;
`endif
        if (f[i]) m_pend[i] = 1;
        else if ((ack_ok && g == i) || (hit && bus.addr[1:0] == 2'd3 && bus.wdata[0])) m_pend[i] = 0;
        if (hit && bus.addr[1:0] == 2'd0) m_cmp[i] = bus.wdata;
        else if (f[i] && rl) m_cmp[i] = m_cmp[i] + m_period[i];
        if (hit && bus.addr[1:0] == 2'd1) m_period[i] = bus.wdata;
        if (hit && bus.addr[1:0] == 2'd2) begin
          m_en[i] = bus.wdata[0]; m_per[i] = bus.wdata[1];
        end else if (f[i] && !rl) m_en[i] = 0;
      end
      if (ack_ok) m_rr = (g + 1) % NCH;
      m_tq = timer;
    end
    @(posedge clk);
    #1;
    check("irq", {31'b0, bus.irq}, {31'b0, |m_pend});
    check("irq_id", {30'b0, bus.irq_id}, m_grant());
    check("rdata", bus.rdata, m_rdata);
  endtask

  task automatic wr(input int c, input int r, input logic [31:0] d);
    bus.sel = 1; bus.we = 1; bus.addr = 4'(c * 4 + r); bus.wdata = d;
    step();
    bus.sel = 0; bus.we = 0;
  endtask

  task automatic rd(input int c, input int r);
    bus.sel = 1; bus.re = 1; bus.addr = 4'(c * 4 + r);
    step();
    bus.sel = 0; bus.re = 0;
  endtask

  task automatic do_ack();
    bus.irq_ack = 1;
    step();
    bus.irq_ack = 0;
  endtask

  initial begin
    int fires;
    bus.sel = 0; bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0; bus.irq_ack = 0;
    rst = 1;
    step();
    check("rst_irq", {31'b0, bus.irq}, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 0;

    // One-shot on ch0.
    wr(0, 0, 5); wr(0, 2, 1);
    for (int t = 0; t < 5; t++) begin
      timer = t;
      repeat (3) step();
    end
    timer = 5;
    step();
    check("oneshot_irq", {31'b0, bus.irq}, 1);
    check("oneshot_id", {30'b0, bus.irq_id}, 0);
    rd(0, 2);
    check("oneshot_en_off", bus.rdata, 0);
    do_ack();
    check("oneshot_ack", {31'b0, bus.irq}, 0);
    repeat (3) step();
    check("oneshot_no_refire", {31'b0, bus.irq}, 0);

    // Periodic reload on ch1.
    wr(1, 0, 10); wr(1, 1, 4); wr(1, 2, 3);
    fires = 0;
    for (int t = 6; t < 20; t++) begin
      timer = t;
      repeat (2) begin
        if (bus.irq) begin
          check("periodic_id", {30'b0, bus.irq_id}, 1);
          fires++;
          do_ack();
        end else step();
      end
    end
    check("periodic_fires", fires, 3);
    rd(1, 0);
    check("periodic_cmp", bus.rdata, 22);
    wr(1, 2, 0);

    // Wrap-around on ch2.
    wr(2, 0, 2); wr(2, 1, 4); wr(2, 2, 3);
    for (int t = 0; t < 5; t++) begin
      timer = 32'hFFFF_FFFE + 32'(t);
      step();
    end
    check("wrap_irq", {31'b0, bus.irq}, 1);
    check("wrap_id", {30'b0, bus.irq_id}, 2);
    do_ack();
    rd(2, 0);
    check("wrap_cmp", bus.rdata, 6);
    wr(2, 2, 0);

    // Round-robin between ch0 and ch3 from rr=0.
    rst = 1; step(); rst = 0;
    wr(0, 0, 7); wr(0, 2, 1); wr(3, 0, 7); wr(3, 2, 1);
    timer = 7;
    step();
    check("rr_first", {30'b0, bus.irq_id}, 0);
    do_ack();
    check("rr_second_irq", {31'b0, bus.irq}, 1);
    check("rr_second", {30'b0, bus.irq_id}, 3);
    do_ack();
    check("rr_done", {31'b0, bus.irq}, 0);

    // Collisions on ch1.
    wr(1, 0, 9); wr(1, 1, 3); wr(1, 2, 3);
    timer = 8; step();
    timer = 9; wr(1, 3, 1);
    check("w1c_vs_fire_irq", {31'b0, bus.irq}, 1);
    rd(1, 3);
    check("w1c_vs_fire_status", bus.rdata, 1);
    do_ack();
    timer = 12; wr(1, 0, 50);
    rd(1, 0);
    check("cmp_write_wins", bus.rdata, 50);
    do_ack();
    wr(1, 2, 0);

    // Overrun.
    wr(1, 0, 20); wr(1, 1, 1); wr(1, 2, 3);
    timer = 20; step();
    timer = 21; step();
    rd(1, 3);
`ifdef TIMER_SCHED_OVERRUN_EN
    check("overrun_status", bus.rdata, 3);
`else
    check("overrun_status", bus.rdata, 1);
`endif
    wr(1, 3, 2);
    rd(1, 3);
    check("overrun_cleared", bus.rdata, 1);

    // Reset while irq is up.
    check("pre_reset_irq", {31'b0, bus.irq}, 1);
    rst = 1; step(); rst = 0;
    check("reset_irq", {31'b0, bus.irq}, 0);
    for (int a = 0; a < 16; a++) begin
      rd(a / 4, a % 4);
      check("reset_reg", bus.rdata, 0);
    end

    // Randomized traffic over a small timer range so deadlines actually hit.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 3) timer = $urandom_range(0, 15);
      bus.sel = 0; bus.we = 0; bus.re = 0;
      if ($urandom_range(0, 1) == 1) begin
        bus.sel = 1;
        if ($urandom_range(0, 1) == 1) bus.we = 1; else bus.re = 1;
        bus.addr = 4'($urandom_range(0, 15));
        case (bus.addr[1:0])
          2'd0: bus.wdata = $urandom_range(0, 15);
          2'd1: bus.wdata = $urandom_range(0, 3);
          default: bus.wdata = $urandom_range(0, 3);
        endcase
      end
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 0; bus.sel = 0; bus.we = 0; bus.re = 0; bus.irq_ack = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
